cpu_ctrl_seq: RTL and testbench

- Microsequencer for the 8-bit accumulator CPU datapath.
- Replaces the free-running 2-bit T counter with a variable-length FSM: FETCH, EX1, optional EX2, plus IDLE (single-step wait) and HALT.
- Decodes IR and drives every bus-driver enable, register load, PC control and ALU op.
- Guarantees at most one bus driver per cycle and supports run/single-step control from the debug bench.

---
 rtl/cpu_ctrl_pkg.sv | 74 +++++++
 rtl/cpu_ctrl_decode.sv | 36 +++
 rtl/cpu_ctrl_seq.sv | 142 ++++++++++++++
 tb/tb_cpu_ctrl_seq.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared opcodes, ALU codes, state encoding and decode record for the microsequencer
package cpu_ctrl_pkg;

    localparam int NREG = 7;
    localparam int OPW  = 4;
    localparam int ALUW = 3;

    // Opcodes, IR[7:4]
    localparam logic [OPW-1:0] OP_NOP  = 4'h0;
    localparam logic [OPW-1:0] OP_LDI  = 4'h1;
    localparam logic [OPW-1:0] OP_ADD  = 4'h2;
    localparam logic [OPW-1:0] OP_SUB  = 4'h3;
    localparam logic [OPW-1:0] OP_AND  = 4'h4;
    localparam logic [OPW-1:0] OP_OR   = 4'h5;
    localparam logic [OPW-1:0] OP_XOR  = 4'h6;
    localparam logic [OPW-1:0] OP_MOV  = 4'h7;
    localparam logic [OPW-1:0] OP_NOT  = 4'h8;
    localparam logic [OPW-1:0] OP_LDR  = 4'h9;
    localparam logic [OPW-1:0] OP_INC  = 4'hA;
    localparam logic [OPW-1:0] OP_LD8  = 4'hB;
    localparam logic [OPW-1:0] OP_JMP  = 4'hC;
    localparam logic [OPW-1:0] OP_NOPD = 4'hD;
    localparam logic [OPW-1:0] OP_NOPE = 4'hE;
    localparam logic [OPW-1:0] OP_HLT  = 4'hF;

    // ALU operation codes
    localparam logic [ALUW-1:0] ALU_ADD   = 3'd0;
    localparam logic [ALUW-1:0] ALU_SUB   = 3'd1;
    localparam logic [ALUW-1:0] ALU_AND   = 3'd2;
    localparam logic [ALUW-1:0] ALU_OR    = 3'd3;
    localparam logic [ALUW-1:0] ALU_XOR   = 3'd4;
    localparam logic [ALUW-1:0] ALU_NOT   = 3'd5;
    localparam logic [ALUW-1:0] ALU_PASSB = 3'd6;
    localparam logic [ALUW-1:0] ALU_INC   = 3'd7;

    // Sequencer states
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_EX1   = 3'd2;
    localparam logic [2:0] ST_EX2   = 3'd3;
    localparam logic [2:0] ST_HALT  = 3'd4;

    // Instruction class flags produced by the decoder
    typedef struct packed {
        logic             is_ldi;
        logic             is_ld8;
        logic             is_jmp;
        logic             is_bin;
        logic             is_unary;
        logic             is_mov;
        logic             is_hlt;
        logic [NREG-1:0]  n_onehot;
        logic [ALUW-1:0]  alu_op;
    } decode_t;

    // ALU operation implied by an opcode; non-ALU opcodes map to 0
    function automatic logic [ALUW-1:0] alu_op_of(input logic [OPW-1:0] op);
        logic [ALUW-1:0] code;
        code = ALU_ADD;
        case (op)
            OP_ADD: code = ALU_ADD;
            OP_SUB: code = ALU_SUB;
            OP_AND: code = ALU_AND;
            OP_OR:  code = ALU_OR;
            OP_XOR: code = ALU_XOR;
            OP_NOT: code = ALU_NOT;
            OP_LDR: code = ALU_PASSB;
            OP_INC: code = ALU_INC;
            default: code = ALU_ADD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/cpu_ctrl_decode.sv
// rtl/cpu_ctrl_decode.sv - combinational IR decode into class flags, one-hot register select and ALU op
module cpu_ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [7:0] ir_q,
    output decode_t    dec
);

    logic [OPW-1:0] op;
    logic [2:0]     n;
    logic           unused_low3;

    assign op = ir_q[7:4];
    assign n  = ir_q[2:0];

    // low[3] carries no meaning in the operand field
    assign unused_low3 = ir_q[3];

    // Classify the opcode and build the register select; R0 does not exist so n=0 selects nothing
    always_comb begin
        dec          = '0;
        dec.is_ldi   = (op == OP_LDI);
        dec.is_ld8   = (op == OP_LD8);
        dec.is_jmp   = (op == OP_JMP);
        dec.is_bin   = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
                       (op == OP_OR)  || (op == OP_XOR) || (op == OP_LDR);
        dec.is_unary = (op == OP_NOT) || (op == OP_INC);
        dec.is_mov   = (op == OP_MOV);
        dec.is_hlt   = (op == OP_HLT);
        for (int i = 0; i < NREG; i++) begin
            dec.n_onehot[i] = (n == 3'(i + 1));
        end
        dec.alu_op   = alu_op_of(op);
    end

endmodule

// File: rtl/cpu_ctrl_seq.sv
// rtl/cpu_ctrl_seq.sv - variable-length microsequencer FSM driving the accumulator CPU datapath controls
module cpu_ctrl_seq
    import cpu_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             step,
    input  logic [7:0]       ir_q,
    output logic             rom_read,
    output logic             ir_load,
    output logic             pc_enable,
    output logic             pc_load,
    output logic             imm4_out_en,
    output logic             rom_bus_en,
    output logic             acc_out_en,
    output logic             alu_out_en,
    output logic [NREG-1:0]  r_out_en,
    output logic             acc_load_en,
    output logic             b_load,
    output logic [NREG-1:0]  r_load_en,
    output logic [ALUW-1:0]  alu_op,
    output logic             instr_done,
    output logic             halted,
    output logic             busy
);

    logic [2:0] state;
    logic [2:0] state_next;
    decode_t    dec;
    logic       needs_ex2;

    cpu_ctrl_decode u_decode (
        .ir_q (ir_q),
        .dec  (dec)
    );

    assign needs_ex2 = dec.is_bin | dec.is_unary | dec.is_mov;

    // State register; reset wins even mid-instruction
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: short instructions finish in EX1, ALU ops and MOV take EX2, HALT is sticky
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  state_next = (run || step) ? ST_FETCH : ST_IDLE;
            ST_FETCH: state_next = ST_EX1;
            ST_EX1: begin
                if (dec.is_hlt) begin
                    state_next = ST_HALT;
                end else if (needs_ex2) begin
                    state_next = ST_EX2;
                end else begin
                    state_next = run ? ST_FETCH : ST_IDLE;
                end
            end
            ST_EX2:   state_next = run ? ST_FETCH : ST_IDLE;
            ST_HALT:  state_next = ST_HALT;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Control outputs; each state drives at most one bus source
    always_comb begin
        rom_read    = 1'b0;
        ir_load     = 1'b0;
        pc_enable   = 1'b0;
        pc_load     = 1'b0;
        imm4_out_en = 1'b0;
        rom_bus_en  = 1'b0;
        acc_out_en  = 1'b0;
        alu_out_en  = 1'b0;
        r_out_en    = '0;
        acc_load_en = 1'b0;
        b_load      = 1'b0;
        r_load_en   = '0;
        alu_op      = '0;
        instr_done  = 1'b0;
        case (state)
            ST_FETCH: begin
                rom_read  = 1'b1;
                ir_load   = 1'b1;
                pc_enable = 1'b1;
            end
            ST_EX1: begin
                alu_op = dec.alu_op;
                if (dec.is_ldi) begin
                    imm4_out_en = 1'b1;
                    acc_load_en = 1'b1;
                    instr_done  = 1'b1;
                end else if (dec.is_ld8) begin
                    rom_read    = 1'b1;
                    rom_bus_en  = 1'b1;
                    acc_load_en = 1'b1;
                    pc_enable   = 1'b1;
                    instr_done  = 1'b1;
                end else if (dec.is_jmp) begin
                    rom_read    = 1'b1;
                    rom_bus_en  = 1'b1;
                    pc_load     = 1'b1;
                    instr_done  = 1'b1;
                end else if (dec.is_bin) begin
                    // With n=0 nothing drives the bus, so B must not latch it
                    r_out_en = dec.n_onehot;
                    b_load   = |dec.n_onehot;
                end else if (dec.is_mov) begin
                    acc_out_en = 1'b1;
                end else if (dec.is_unary) begin
                    instr_done = 1'b0;
                end else begin
                    // HLT and the NOP opcodes end here
                    instr_done = 1'b1;
                end
            end
            ST_EX2: begin
                alu_op     = dec.alu_op;
                instr_done = 1'b1;
                if (dec.is_mov) begin
                    acc_out_en = 1'b1;
                    r_load_en  = dec.n_onehot;
                end else begin
                    alu_out_en  = 1'b1;
                    acc_load_en = 1'b1;
                end
            end
            default: begin
                alu_op = '0;
            end
        endcase
    end

    assign halted = (state == ST_HALT);
    assign busy   = (state == ST_FETCH) || (state == ST_EX1) || (state == ST_EX2);

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// tb/tb_cpu_ctrl_seq.sv - self-checking bench for cpu_ctrl_seq against an instruction-level reference model
module tb_cpu_ctrl_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       run;
    logic       step;
    logic [7:0] ir_q;
    logic       rom_read, ir_load, pc_enable, pc_load;
    logic       imm4_out_en, rom_bus_en, acc_out_en, alu_out_en;
    logic [6:0] r_out_en;
    logic       acc_load_en, b_load;
    logic [6:0] r_load_en;
    logic [2:0] alu_op;
    logic       instr_done, halted, busy;

    cpu_ctrl_seq dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .step        (step),
        .ir_q        (ir_q),
        .rom_read    (rom_read),
        .ir_load     (ir_load),
        .pc_enable   (pc_enable),
        .pc_load     (pc_load),
        .imm4_out_en (imm4_out_en),
        .rom_bus_en  (rom_bus_en),
        .acc_out_en  (acc_out_en),
        .alu_out_en  (alu_out_en),
        .r_out_en    (r_out_en),
        .acc_load_en (acc_load_en),
        .b_load      (b_load),
        .r_load_en   (r_load_en),
        .alu_op      (alu_op),
        .instr_done  (instr_done),
        .halted      (halted),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rom_read, ir_load, pc_enable, pc_load;
        logic       imm4, rom_bus, acc_out, alu_out;
        logic [6:0] r_out;
        logic       acc_load, b_load;
        logic [6:0] r_load;
        logic [2:0] alu_op;
        logic       done, halted, busy;
    } obs_t;

    typedef enum {M_IDLE, M_BUSY, M_HALT} mmode_t;

    int     tests = 0;
    int     fails = 0;
    mmode_t m_mode = M_IDLE;
    int     m_pos = 0;
    logic   started = 1'b0;

    // Cycles per instruction: fetch plus one or two execute cycles
    function automatic int instr_len(input logic [7:0] ir);
        return (ir[7:4] >= 4'h2 && ir[7:4] <= 4'hA) ? 3 : 2;
    endfunction

    function automatic logic [2:0] alu_code(input logic [3:0] op);
        case (op)
            4'h3: return 3'd1;
            4'h4: return 3'd2;
            4'h5: return 3'd3;
            4'h6: return 3'd4;
            4'h8: return 3'd5;
            4'h9: return 3'd6;
            4'hA: return 3'd7;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic [6:0] reg_sel(input logic [7:0] ir);
        logic [6:0] r;
        int n;
        r = '0;
        n = int'(ir[2:0]);
        if (n != 0) r[n-1] = 1'b1;
        return r;
    endfunction

    // Expected control word for the cycle the model is currently in
    function automatic obs_t expected();
        obs_t e;
        logic [3:0] op;
        e = '0;
        op = ir_q[7:4];
        if (m_mode == M_HALT) begin
            e.halted = 1'b1;
        end else if (m_mode == M_BUSY) begin
            e.busy = 1'b1;
            if (m_pos == 0) begin
                e.rom_read = 1'b1; e.ir_load = 1'b1; e.pc_enable = 1'b1;
            end else begin
                e.alu_op = alu_code(op);
                e.done = (m_pos == instr_len(ir_q) - 1);
                if (m_pos == 1) begin
                    case (op)
                        4'h1: begin e.imm4 = 1'b1; e.acc_load = 1'b1; end
                        4'hB: begin e.rom_read = 1'b1; e.rom_bus = 1'b1; e.acc_load = 1'b1; e.pc_enable = 1'b1; end
                        4'hC: begin e.rom_read = 1'b1; e.rom_bus = 1'b1; e.pc_load = 1'b1; end
                        4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h9: begin
                            e.r_out = reg_sel(ir_q);
                            e.b_load = (ir_q[2:0] != 3'd0);
                        end
                        4'h7: e.acc_out = 1'b1;
                        default: e.acc_out = 1'b0;
                    endcase
                end else if (op == 4'h7) begin
                    e.acc_out = 1'b1; e.r_load = reg_sel(ir_q);
                end else begin
                    e.alu_out = 1'b1; e.acc_load = 1'b1;
                end
            end
        end
        return e;
    endfunction

    function automatic obs_t observed();
        obs_t o;
        o = {rom_read, ir_load, pc_enable, pc_load, imm4_out_en, rom_bus_en, acc_out_en, alu_out_en,
             r_out_en, acc_load_en, b_load, r_load_en, alu_op, instr_done, halted, busy};
        return o;
    endfunction

    // Model advance at a clock edge using the inputs held across that edge
    task automatic model_step();
        if (reset) begin
            m_mode = M_IDLE;
        end else if (m_mode == M_IDLE) begin
            if (run || step) begin m_mode = M_BUSY; m_pos = 0; end
        end else if (m_mode == M_BUSY) begin
            if (m_pos == instr_len(ir_q) - 1) begin
                if (ir_q[7:4] == 4'hF) m_mode = M_HALT;
                else if (run) m_pos = 0;
                else m_mode = M_IDLE;
            end else begin
                m_pos = m_pos + 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        started = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b1; run = 1'b0; step = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    // Bus one-driver invariant, every cycle
    always @(negedge clk) begin
        if (started) begin
            tests = tests + 1;
            if (int'(imm4_out_en) + int'(rom_bus_en) + int'(acc_out_en) + int'(alu_out_en) + $countones(r_out_en) > 1) begin
                fails = fails + 1;
                $display("FAIL bus_invariant t=%0t drivers imm4=%b rom=%b acc=%b alu=%b r=%b, required at most one",
                         $time, imm4_out_en, rom_bus_en, acc_out_en, alu_out_en, r_out_en);
            end
        end
    end

    task automatic test_reset();
        obs_t o, e;
        reset = 1'b1; run = 1'b1; step = 1'b1; ir_q = 8'h23;
        for (int c = 0; c < 2; c++) begin
            tick();
            o = observed(); e = expected();
            tests = tests + 1;
            if (o !== e || o !== obs_t'(0)) begin
                fails = fails + 1;
                $display("FAIL reset c%0d got %h want %h", c, o, e);
            end
        end
        reset = 1'b0; run = 1'b0; step = 1'b0;
    endtask

    task automatic test_ldi();
        obs_t o, e;
        do_reset();
        ir_q = 8'h15; run = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            o = observed(); e = expected();
            tests = tests + 1;
            if (o !== e) begin
                fails = fails + 1;
                $display("FAIL ldi c%0d got %h want %h", c, o, e);
            end
        end
    endtask

    task automatic test_alu_mov(input logic [7:0] ir, input string name);
        obs_t o, e;
        do_reset();
        ir_q = ir; run = 1'b1;
        for (int c = 0; c < 7; c++) begin
            tick();
            o = observed(); e = expected();
            tests = tests + 1;
            if (o !== e) begin
                fails = fails + 1;
                $display("FAIL %s c%0d got %h want %h", name, c, o, e);
            end
        end
    endtask

    task automatic test_single_step();
        obs_t o, e;
        int dones;
        do_reset();
        ir_q = 8'hC0; dones = 0;
        for (int c = 0; c < 16; c++) begin
            step = (c == 3 || c == 5 || c == 10);
            tick();
            o = observed(); e = expected();
            tests = tests + 1;
            if (o !== e) begin
                fails = fails + 1;
                $display("FAIL single_step c%0d got %h want %h", c, o, e);
            end
            if (instr_done === 1'b1) dones = dones + 1;
        end
        step = 1'b0;
        tests = tests + 1;
        if (dones !== 2) begin
            fails = fails + 1;
            $display("FAIL step_count got %0d want 2", dones);
        end
    endtask

    task automatic test_halt();
        obs_t o, e;
        do_reset();
        ir_q = 8'hF0; run = 1'b1;
        for (int c = 0; c < 22; c++) begin
            if (c >= 2) begin
                run = 1'($urandom_range(0, 1));
                step = 1'($urandom_range(0, 1));
            end
            tick();
            o = observed(); e = expected();
            tests = tests + 1;
            if (o !== e) begin
                fails = fails + 1;
                $display("FAIL halt c%0d got %h want %h", c, o, e);
            end
        end
        reset = 1'b1;
        tick();
        reset = 1'b0; run = 1'b0; step = 1'b0;
        o = observed();
        tests = tests + 1;
        if (o !== obs_t'(0)) begin
            fails = fails + 1;
            $display("FAIL halt_exit got %h want 0", o);
        end
    endtask

    task automatic test_reset_mid();
        obs_t o, e;
        do_reset();
        ir_q = 8'h23; run = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            o = observed(); e = expected();
            tests = tests + 1;
            if (o !== e) begin
                fails = fails + 1;
                $display("FAIL reset_mid_pre c%0d got %h want %h", c, o, e);
            end
        end
        reset = 1'b1;
        tick();
        reset = 1'b0; run = 1'b0;
        o = observed();
        tests = tests + 1;
        if (o !== obs_t'(0)) begin
            fails = fails + 1;
            $display("FAIL reset_mid got %h want 0", o);
        end
        tick();
        o = observed();
        tests = tests + 1;
        if (o !== obs_t'(0)) begin
            fails = fails + 1;
            $display("FAIL reset_mid_idle got %h want 0", o);
        end
    endtask

    task automatic test_random();
        obs_t o, e;
        do_reset();
        ir_q = 8'($urandom);
        for (int c = 0; c < 10000; c++) begin
            reset = (m_mode == M_HALT) && ($urandom_range(0, 3) == 0);
            run = ($urandom_range(0, 9) != 0);
            step = 1'($urandom_range(0, 1));
            tick();
            o = observed(); e = expected();
            tests = tests + 1;
            if (o !== e) begin
                fails = fails + 1;
                $display("FAIL random c%0d ir=%h got %h want %h", c, ir_q, o, e);
            end
            if (m_mode != M_BUSY || m_pos == 0) ir_q = 8'($urandom);
        end
        reset = 1'b0; run = 1'b0; step = 1'b0;
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; step = 1'b0; ir_q = 8'h00;
        test_reset();
        test_ldi();
        test_alu_mov(8'h23, "add_r3");
        test_alu_mov(8'h7A, "mov_r2");
        test_alu_mov(8'h20, "add_r0");
        test_alu_mov(8'h75, "mov_r5");
        test_alu_mov(8'hA0, "inc");
        test_alu_mov(8'hB0, "ld8");
        test_single_step();
        test_halt();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
